// File: rtl/complex_mvm_band3_ctrl.sv
// Banded 3-tap complex single-precision MVM, one complex MAC per cycle.
// Optional CMVM_CONJ_EN: conjugate vector entries when latched.
module complex_mvm_band3_ctrl #(
  parameter int ROWS  = 8,
  parameter int NCOEF = 7,
  parameter int NVEC  = 3,
  parameter int CW    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NCOEF*CW-1:0]   mat,
  input  logic [NVEC*CW-1:0]    vector,
  output logic [ROWS*CW-1:0]    out,
  output logic                  finish,
  output logic                  outsider_read_now
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_n;
  logic        start_q, req;
  logic [2:0]  row;
  logic [1:0]  term;
  logic [3:0]  k;
  logic [2:0]  kidx;
  logic [63:0] acc, acc_in, acc_n, cf, vv;
  logic [31:0] p_re, p_im;
  logic [63:0] mat_q [NCOEF];
  logic [63:0] vec_q [NVEC];

  // Truncating multiply; zero/denormal in or out gives +0
  function automatic logic [31:0] fmul(input logic [31:0] a,
                                       input logic [31:0] b);
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [22:0]       m;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]})
      - 10'sd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'sd1;
    end else begin
      m = p[45:23];
    end
    if (e >= 10'sd255) return {a[31] ^ b[31], 8'hff, 23'd0};
    if (e <= 10'sd0) return 32'd0;
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  // Truncating add; three guard bits plus sticky keep the floor exact
  function automatic logic [31:0] fadd(input logic [31:0] a,
                                       input logic [31:0] b);
    logic [31:0]       x, y;
    logic [7:0]        d;
    logic [26:0]       xs, ys, yal, n;
    logic [27:0]       s;
    logic [4:0]        lz;
    logic signed [9:0] e;
    logic [22:0]       m;
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return 32'd0;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = x[30:23] - y[30:23];
    xs = {1'b1, x[22:0], 3'b000};
    ys = {1'b1, y[22:0], 3'b000};
    if (d >= 8'd27) begin
      yal = 27'd1;
    end else begin
      yal    = ys >> d;
      yal[0] = yal[0] | (|(ys & ((27'd1 << d) - 27'd1)));
    end
    e = $signed({2'b0, x[30:23]});
    if (x[31] == y[31]) begin
      s = {1'b0, xs} + {1'b0, yal};
      if (s[27]) begin
        m = s[26:4];
        e = e + 10'sd1;
      end else begin
        m = s[25:3];
      end
    end else begin
      s = {1'b0, xs} - {1'b0, yal};
      if (s == 28'd0) return 32'd0;
      lz = '0;
      for (int i = 0; i < 27; i++)
        if (s[i]) lz = 5'(26 - i);
      n = s[26:0] << lz;
      m = n[25:3];
      e = e - $signed({5'd0, lz});
    end
    if (e >= 10'sd255) return {x[31], 8'hff, 23'd0};
    if (e <= 10'sd0) return 32'd0;
    return {x[31], e[7:0], m};
  endfunction

  assign req = start & ~start_q;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req) state_n = CALC;
      CALC:    if (row == 3'd7 && term == 2'd2) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Band index k = row + term - 1; k outside 0..6 is a zero coefficient
  always_comb begin
    k    = {1'b0, row} + {2'b0, term};
    kidx = 3'(k - 4'd1);
    cf   = '0;
    if (k != 4'd0 && k <= 4'd7) cf = mat_q[kidx];
    vv   = vec_q[term];
    p_re = fadd(fmul(cf[63:32], vv[63:32]),
                fmul(cf[31:0], vv[31:0]) ^ 32'h8000_0000);
    p_im = fadd(fmul(cf[63:32], vv[31:0]),
                fmul(cf[31:0], vv[63:32]));
    acc_in = (term == 2'd0) ? 64'd0 : acc;
    acc_n  = {fadd(acc_in[63:32], p_re), fadd(acc_in[31:0], p_im)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q           <= 1'b0;
      row               <= '0;
      term              <= '0;
      acc               <= '0;
      out               <= '0;
      finish            <= 1'b0;
      outsider_read_now <= 1'b0;
      for (int i = 0; i < NCOEF; i++) mat_q[i] <= '0;
      for (int j = 0; j < NVEC; j++)  vec_q[j] <= '0;
    end else begin
      start_q <= start;
      finish  <= 1'b0;
      unique case (state)
        IDLE: if (req) begin
          for (int i = 0; i < NCOEF; i++)
            mat_q[i] <= mat[i*CW +: CW];
          for (int j = 0; j < NVEC; j++)
`ifdef CMVM_CONJ_EN
            vec_q[j] <= vector[j*CW +: CW] ^ 64'h0000_0000_8000_0000;
`else
            vec_q[j] <= vector[j*CW +: CW];
`endif
          outsider_read_now <= 1'b0;
          row  <= '0;
          term <= '0;
        end
        CALC: begin
          acc <= acc_n;
          if (term == 2'd2) begin
            out[{row, 6'd0} +: CW] <= acc_n;
            term <= '0;
            row  <= row + 3'd1;
          end else begin
            term <= term + 2'd1;
          end
        end
        DONE: begin
          finish            <= 1'b1;
          outsider_read_now <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_mvm_band3_ctrl.sv
// Bench for complex_mvm_band3_ctrl: directed cases plus random
// operands against a real-arithmetic truncating reference model.
module tb_complex_mvm_band3_ctrl;

  localparam logic [63:0] ONE = 64'h3f800000_00000000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [447:0] mat;
  logic [191:0] vector;
  logic [511:0] out;
  logic         finish;
  logic         outsider_read_now;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  complex_mvm_band3_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .mat               (mat),
    .vector            (vector),
    .out               (out),
    .finish            (finish),
    .outsider_read_now (outsider_read_now)
  );

  function automatic real pow2(input int e);
    real p;
    p = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
    else        for (int i = 0; i < -e; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic real s2r(input logic [31:0] b);
    real v;
    if (b[30:23] == 8'd0) return 0.0;
    v = (1.0 + $itor(b[22:0]) / 8388608.0)
      * pow2(int'(b[30:23]) - 127);
    return b[31] ? -v : v;
  endfunction

  // Exact real value truncated toward zero into a single
  function automatic logic [31:0] r2s(input real r);
    real  a, p;
    int   e, mant;
    logic s;
    if (r == 0.0) return 32'd0;
    s = (r < 0.0);
    a = s ? -r : r;
    p = 1.0;
    e = 0;
    while (a >= 2.0 * p) begin p = p * 2.0; e++; end
    while (a < p) begin p = p / 2.0; e--; end
    if (e + 127 >= 255) return {s, 8'hff, 23'd0};
    if (e + 127 <= 0) return 32'd0;
    mant = $rtoi((a / p - 1.0) * 8388608.0);
    return {s, 8'(e + 127), 23'(mant)};
  endfunction

  function automatic logic [63:0] cmul(input logic [63:0] c,
                                       input logic [63:0] v);
    real ar, ai, br, bi;
    logic [31:0] rr, ii, ri, ir;
    ar = s2r(c[63:32]); ai = s2r(c[31:0]);
    br = s2r(v[63:32]); bi = s2r(v[31:0]);
    rr = r2s(ar * br); ii = r2s(ai * bi);
    ri = r2s(ar * bi); ir = r2s(ai * br);
    return {r2s(s2r(rr) - s2r(ii)), r2s(s2r(ri) + s2r(ir))};
  endfunction

  function automatic logic [511:0] model(input logic [447:0] m,
                                         input logic [191:0] v);
    logic [511:0] y;
    logic [63:0]  acc, c, vj, p;
    int k;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      acc = '0;
      for (int j = 0; j < 3; j++) begin
        k  = i + j - 1;
        c  = (k < 0 || k > 6) ? 64'd0 : m[64*k +: 64];
        vj = v[64*j +: 64];
`ifdef CMVM_CONJ_EN
        vj[31] = ~vj[31];
`endif
        p   = cmul(c, vj);
        acc = {r2s(s2r(acc[63:32]) + s2r(p[63:32])),
               r2s(s2r(acc[31:0]) + s2r(p[31:0]))};
      end
      y[64*i +: 64] = acc;
    end
    return y;
  endfunction

  // Magnitudes in [0.5,4) keep every model step exact in double
  function automatic logic [31:0] rnd_f();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(126, 128)),
            23'($urandom)};
  endfunction

  function automatic logic [63:0] rnd_c();
    if ($urandom_range(0, 5) == 0) return 64'd0;
    return {rnd_f(), rnd_f()};
  endfunction

  function automatic logic [447:0] rnd_mat();
    logic [447:0] m;
    for (int i = 0; i < 7; i++) m[64*i +: 64] = rnd_c();
    return m;
  endfunction

  function automatic logic [191:0] rnd_vec();
    logic [191:0] v;
    for (int j = 0; j < 3; j++) v[64*j +: 64] = rnd_c();
    return v;
  endfunction

  task automatic do_run(input logic [447:0] m, input logic [191:0] v,
                        output int lat);
    @(negedge clk);
    mat = m; vector = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (finish) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; mat = '0; vector = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out !== 512'd0) begin
      n_err++; $display("FAIL reset_out: got %h want 0", out);
    end
    n_cmp++;
    if (finish !== 1'b0) begin
      n_err++; $display("FAIL reset_finish: got %b want 0", finish);
    end
    n_cmp++;
    if (outsider_read_now !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 0", outsider_read_now);
    end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ones();
    logic [63:0] exp_y [8];
    int lat;
    exp_y[0] = 64'h40000000_00000000;
    for (int i = 1; i < 6; i++) exp_y[i] = 64'h40400000_00000000;
    exp_y[6] = 64'h40000000_00000000;
    exp_y[7] = 64'h3f800000_00000000;
    do_run({7{ONE}}, {3{ONE}}, lat);
    n_cmp++;
    if (lat !== 25) begin
      n_err++; $display("FAIL ones_latency: got %0d want 25", lat);
    end
    n_cmp++;
    if (outsider_read_now !== 1'b1) begin
      n_err++; $display("FAIL ones_ready: got %b want 1",
                        outsider_read_now);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out[64*i +: 64] !== exp_y[i]) begin
        n_err++; $display("FAIL ones_y%0d: got %h want %h",
                          i, out[64*i +: 64], exp_y[i]);
      end
    end
  endtask

  task automatic test_imag();
    logic [63:0] e;
    int lat;
`ifdef CMVM_CONJ_EN
    e = 64'h00000000_bf800000;
`else
    e = 64'h00000000_3f800000;
`endif
    do_run({7{ONE}}, {128'd0, 64'h00000000_3f800000}, lat);
    n_cmp++;
    if (out[63:0] !== 64'd0) begin
      n_err++; $display("FAIL imag_y0: got %h want 0", out[63:0]);
    end
    for (int i = 1; i < 8; i++) begin
      n_cmp++;
      if (out[64*i +: 64] !== e) begin
        n_err++; $display("FAIL imag_y%0d: got %h want %h",
                          i, out[64*i +: 64], e);
      end
    end
  endtask

  task automatic test_single_term();
    logic [447:0] m;
    logic [511:0] e;
    int lat;
    m = '0;
    m[64*3 +: 64] = 64'h40000000_3f800000;
    e = '0;
`ifdef CMVM_CONJ_EN
    e[64*3 +: 64] = 64'h40400000_bf800000;
`else
    e[64*3 +: 64] = 64'h3f800000_40400000;
`endif
    do_run(m, {64'd0, 64'h3f800000_3f800000, 64'd0}, lat);
    n_cmp++;
    if (out !== e) begin
      n_err++; $display("FAIL single_term: got %h want %h", out, e);
    end
  endtask

  task automatic test_handshake();
    int nfin, first;
    logic rd_before, rd_at;
    nfin = 0; first = -1; rd_before = 1'b1; rd_at = 1'b0;
    @(negedge clk);
    mat = {7{ONE}}; vector = {3{ONE}}; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 24) rd_before = outsider_read_now;
      if (c == 25) rd_at = outsider_read_now;
      if (finish) begin
        nfin++;
        if (first < 0) first = c;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (nfin !== 1) begin
      n_err++; $display("FAIL hs_count: got %0d want 1", nfin);
    end
    n_cmp++;
    if (first !== 25) begin
      n_err++; $display("FAIL hs_latency: got %0d want 25", first);
    end
    n_cmp++;
    if (rd_before !== 1'b0) begin
      n_err++; $display("FAIL hs_ready_early: got %b want 0", rd_before);
    end
    n_cmp++;
    if (rd_at !== 1'b1) begin
      n_err++; $display("FAIL hs_ready_rise: got %b want 1", rd_at);
    end
    n_cmp++;
    if (outsider_read_now !== 1'b1) begin
      n_err++; $display("FAIL hs_ready_hold: got %b want 1",
                        outsider_read_now);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [511:0] e;
    @(negedge clk);
    mat = {7{ONE}}; vector = {3{ONE}}; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({out, finish, outsider_read_now} !== 514'd0) begin
      n_err++; $display("FAIL rstmid_outputs: got %h/%b/%b want 0",
                        out, finish, outsider_read_now);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    e = model({7{ONE}}, {3{ONE}});
    do_run({7{ONE}}, {3{ONE}}, lat);
    n_cmp++;
    if (lat !== 25 || out !== e) begin
      n_err++; $display("FAIL rstmid_rerun: lat %0d got %h want %h",
                        lat, out, e);
    end
  endtask

  task automatic test_ignore();
    logic [447:0] m1;
    logic [191:0] v1;
    logic [511:0] e;
    int nfin, first;
    m1 = rnd_mat(); v1 = rnd_vec();
    e = model(m1, v1);
    nfin = 0; first = -1;
    @(negedge clk);
    mat = m1; vector = v1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin start = 1'b1; mat = rnd_mat(); vector = rnd_vec(); end
      if (c == 8) start = 1'b0;
      if (finish) begin
        nfin++;
        if (first < 0) first = c;
      end
    end
    n_cmp++;
    if (nfin !== 1 || first !== 25) begin
      n_err++; $display("FAIL ignore_runs: got %0d runs first %0d want 1 at 25",
                        nfin, first);
    end
    n_cmp++;
    if (out !== e) begin
      n_err++; $display("FAIL ignore_result: got %h want %h", out, e);
    end
  endtask

  task automatic test_random();
    logic [447:0] m;
    logic [191:0] v;
    logic [511:0] e;
    int lat;
    for (int t = 0; t < 6; t++) begin
      m = rnd_mat(); v = rnd_vec();
      e = model(m, v);
      do_run(m, v, lat);
      n_cmp++;
      if (lat !== 25) begin
        n_err++; $display("FAIL rand%0d_latency: got %0d want 25", t, lat);
      end
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (out[64*i +: 64] !== e[64*i +: 64]) begin
          n_err++; $display("FAIL rand%0d_y%0d: got %h want %h",
                            t, i, out[64*i +: 64], e[64*i +: 64]);
        end
      end
    end
  endtask

  task automatic test_boundary();
    logic [63:0] c3 [3];
    logic [63:0] v1 [3];
    logic [63:0] y3 [3];
    logic [447:0] m;
    logic [511:0] e;
    int lat;
    c3[0] = 64'hf1800000_00000000; v1[0] = 64'h71800000_00000000;
    y3[0] = 64'hff800000_00000000;
    c3[1] = 64'h0d800000_00000000; v1[1] = 64'h0d800000_00000000;
    y3[1] = 64'h00000000_00000000;
    c3[2] = 64'h00000001_00400000; v1[2] = ONE;
    y3[2] = 64'h00000000_00000000;
    for (int t = 0; t < 3; t++) begin
      m = '0;
      m[64*3 +: 64] = c3[t];
      e = model(m, {64'd0, v1[t], 64'd0});
      do_run(m, {64'd0, v1[t], 64'd0}, lat);
      n_cmp++;
      if (out[64*3 +: 64] !== y3[t]) begin
        n_err++; $display("FAIL bound%0d_y3: got %h want %h",
                          t, out[64*3 +: 64], y3[t]);
      end
      n_cmp++;
      if (out !== e) begin
        n_err++; $display("FAIL bound%0d_model: got %h want %h",
                          t, out, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_imag();
    test_single_term();
    test_handshake();
    test_reset_mid();
    test_ignore();
    test_random();
    test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
